// File: rtl/osnt_rx_stamp_stats_if.sv
// ---------------------------------------------------------------------------
// osnt_rx_stamp_stats_if
// AXI4-Stream bundle used on both sides of the rx stamp/statistics stage.
//
// Signals
//   tdata   DATA_W      payload
//   tkeep   DATA_W/8    byte enables, contiguous from bit 0
//   tuser   USER_W      sideband (the stage writes the arrival stamp here)
//   tvalid  1           source has a beat
//   tlast   1           final beat of a packet
//   tready  1           sink accepts the beat
//
// Modports
//   master  drives the beat, samples tready
//   slave   samples the beat, drives tready
// ---------------------------------------------------------------------------
interface osnt_rx_stamp_stats_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/osnt_rx_stamp_stats.sv
// ---------------------------------------------------------------------------
// osnt_rx_stamp_stats
// Registered AXI4-Stream pass-through placed after the 100G rx queue. The
// arrival timestamp carried inside beat 0 of every packet is copied into
// tuser, and per-port packet / byte / maximum-length statistics are kept.
// A main register plus one skid register keep full throughput while
// s_axis.tready stays a pure flop output (no path from m_axis.tready).
//
// Ports
//   axis_aclk      in   clock
//   axis_resetn    in   asynchronous active-low reset
//   s_axis         slave  stream from the rx queue
//   m_axis         master stream to downstream logic
//   stats_clear    in   one-cycle pulse, zeroes all statistics
//   stat_pkt_cnt   out  32-bit completed packet count (wraps)
//   stat_byte_cnt  out  64-bit completed byte count (wraps)
//   stat_max_len   out  16-bit longest completed packet in bytes
// ---------------------------------------------------------------------------
module osnt_rx_stamp_stats #(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int AXI_USER_WIDTH  = 128,
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int TIMESTAMP_POS   = 176,
  parameter int TUSER_TS_POS    = 64
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  osnt_rx_stamp_stats_if.slave  s_axis,
  osnt_rx_stamp_stats_if.master m_axis,
  input  logic                  stats_clear,
  output logic [31:0]           stat_pkt_cnt,
  output logic [63:0]           stat_byte_cnt,
  output logic [15:0]           stat_max_len
);

  localparam int KEEP_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(KEEP_W + 1);

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  state_t                    r_state;
  logic                      r_s_ready;
  logic                      r_m_valid;
  logic                      r_skid_valid;
  logic [AXI_DATA_WIDTH-1:0] r_m_data;
  logic [KEEP_W-1:0]         r_m_keep;
  logic [AXI_USER_WIDTH-1:0] r_m_user;
  logic                      r_m_last;
  logic [AXI_DATA_WIDTH-1:0] r_skid_data;
  logic [KEEP_W-1:0]         r_skid_keep;
  logic [AXI_USER_WIDTH-1:0] r_skid_user;
  logic                      r_skid_last;
  logic [15:0]               r_cur_len;
  logic [31:0]               r_pkt_cnt;
  logic [63:0]               r_byte_cnt;
  logic [15:0]               r_max_len;

  logic                      w_accept;
  logic                      w_out_ready;
  logic [AXI_USER_WIDTH-1:0] w_in_user;
  logic [CNT_W-1:0]          w_keep_cnt;
  logic [16:0]               w_len_sum;
  logic [15:0]               w_len_new;

  assign w_accept    = s_axis.tvalid && r_s_ready;
  assign w_out_ready = !r_m_valid || m_axis.tready;

  // The first beat of a packet gets the stamp embedded in its data copied
  // into tuser; every other bit, and every later beat, passes untouched.
  always_comb begin
    w_in_user = s_axis.tuser;
    if (r_state == ST_IDLE)
      w_in_user[TUSER_TS_POS +: TIMESTAMP_WIDTH] = s_axis.tdata[TIMESTAMP_POS +: TIMESTAMP_WIDTH];
  end

  // Byte count of the incoming beat. tkeep is contiguous, but counting the
  // ones keeps this independent of that assumption.
  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++)
      w_keep_cnt = w_keep_cnt + CNT_W'(s_axis.tkeep[i]);
  end

  // Running packet length including this beat, clamped at the 16-bit ceiling
  // so jumbo or runaway packets report 0xFFFF rather than wrapping short.
  assign w_len_sum = {1'b0, r_cur_len} + 17'(w_keep_cnt);
  assign w_len_new = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

  // Occupancy control for the main/skid pair. tready is registered and only
  // falls once the skid holds a beat, so the upstream can always land one
  // more beat after the downstream stalls. A full skid empties into main
  // on the next cycle main can move, which keeps beat order intact.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_m_valid    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
    end else if (w_out_ready) begin
      r_m_valid    <= r_skid_valid || w_accept;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b1;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_s_ready    <= 1'b0;
    end else begin
      r_s_ready    <= !r_skid_valid;
    end
  end

  // Payload registers carry no reset: their contents only matter while the
  // matching valid flag is set.
  always_ff @(posedge axis_aclk) begin
    if (w_out_ready) begin
      if (r_skid_valid) begin
        r_m_data <= r_skid_data;
        r_m_keep <= r_skid_keep;
        r_m_user <= r_skid_user;
        r_m_last <= r_skid_last;
      end else if (w_accept) begin
        r_m_data <= s_axis.tdata;
        r_m_keep <= s_axis.tkeep;
        r_m_user <= w_in_user;
        r_m_last <= s_axis.tlast;
      end
    end else if (w_accept) begin
      r_skid_data <= s_axis.tdata;
      r_skid_keep <= s_axis.tkeep;
      r_skid_user <= w_in_user;
      r_skid_last <= s_axis.tlast;
    end
  end

  // Packet tracking and statistics, all driven by input acceptance so the
  // counters do not depend on downstream backpressure. A clear pulse wins
  // over a coincident packet commit, but the in-flight length is kept so a
  // packet spanning the clear is still counted whole when it finishes.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state    <= ST_IDLE;
      r_cur_len  <= '0;
      r_pkt_cnt  <= '0;
      r_byte_cnt <= '0;
      r_max_len  <= '0;
    end else begin
      if (w_accept) begin
        if (s_axis.tlast) begin
          r_state   <= ST_IDLE;
          r_cur_len <= '0;
        end else begin
          r_state   <= ST_PKT;
          r_cur_len <= w_len_new;
        end
      end
      if (stats_clear) begin
        r_pkt_cnt  <= '0;
        r_byte_cnt <= '0;
        r_max_len  <= '0;
      end else if (w_accept && s_axis.tlast) begin
        r_pkt_cnt  <= r_pkt_cnt + 32'd1;
        r_byte_cnt <= r_byte_cnt + 64'(w_len_new);
        r_max_len  <= (w_len_new > r_max_len) ? w_len_new : r_max_len;
      end
    end
  end

  assign s_axis.tready = r_s_ready;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tuser  = r_m_user;
  assign m_axis.tlast  = r_m_last;

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_byte_cnt = r_byte_cnt;
  assign stat_max_len  = r_max_len;

endmodule

// File: tb/tb_osnt_rx_stamp_stats.sv
// ---------------------------------------------------------------------------
// tb_osnt_rx_stamp_stats
// Bench for the rx stamp/statistics stage. A packet-level model keeps a queue
// of beats that must emerge (with the stamp applied to beat 0) plus the
// expected statistics; a compare process checks the DUT against it every
// cycle. Directed scenarios pin the model with literal values, then a random
// phase exercises backpressure, gaps and clears.
// ---------------------------------------------------------------------------
module tb_osnt_rx_stamp_stats;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic        statsClear;
  logic [31:0] statPktCnt;
  logic [63:0] statByteCnt;
  logic [15:0] statMaxLen;

  bit tbReady   = 1'b1;
  bit tbClear   = 1'b0;
  bit randMode  = 1'b0;
  bit randGaps  = 1'b0;
  bit clearNext = 1'b0;

  int passCount  = 0;
  int checkCount = 0;

  beat_t       expQ[$];
  bit          mInPkt  = 1'b0;
  int          mCurLen = 0;
  logic [31:0] mPkt    = '0;
  logic [63:0] mByte   = '0;
  logic [15:0] mMax    = '0;
  bit          postRst = 1'b0;

  osnt_rx_stamp_stats_if #(.DATA_W(DW), .USER_W(UW)) sIf ();
  osnt_rx_stamp_stats_if #(.DATA_W(DW), .USER_W(UW)) mIf ();

  osnt_rx_stamp_stats #(
    .AXI_DATA_WIDTH  (DW),
    .AXI_USER_WIDTH  (UW),
    .TIMESTAMP_WIDTH (64),
    .TIMESTAMP_POS   (176),
    .TUSER_TS_POS    (64)
  ) dut (
    .axis_aclk     (clk),
    .axis_resetn   (resetn),
    .s_axis        (sIf),
    .m_axis        (mIf),
    .stats_clear   (statsClear),
    .stat_pkt_cnt  (statPktCnt),
    .stat_byte_cnt (statByteCnt),
    .stat_max_len  (statMaxLen)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single comparison point: every failure is reported and counted here.
  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Model of one accepted input beat: stamp beat 0, queue it for output,
  // and fold its byte count into the packet/statistics bookkeeping.
  task automatic modelAccept();
    beat_t b;
    int n;
    b.data = sIf.tdata;
    b.keep = sIf.tkeep;
    b.user = sIf.tuser;
    b.last = sIf.tlast;
    if (!mInPkt) b.user[127:64] = sIf.tdata[239:176];
    expQ.push_back(b);
    n = $countones(sIf.tkeep);
    mCurLen = (mCurLen + n > 65535) ? 65535 : mCurLen + n;
    if (sIf.tlast) begin
      mPkt  = mPkt + 32'd1;
      mByte = mByte + 64'(mCurLen);
      if (mCurLen > int'(mMax)) mMax = 16'(mCurLen);
      mCurLen = 0;
      mInPkt  = 1'b0;
    end else begin
      mInPkt = 1'b1;
    end
  endtask

  // Downstream ready and clear pulses: applied 1 time unit after each
  // falling edge, either from the directed control bits or at random.
  initial begin
    mIf.tready = 1'b1;
    statsClear = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (randMode) begin
        mIf.tready = ($urandom_range(0, 3) != 0);
        statsClear = ($urandom_range(0, 31) == 0);
      end else begin
        mIf.tready = tbReady;
        statsClear = tbClear;
      end
    end
  end

  // Compare process: 3 units after each falling edge every input and output
  // holds the value the next rising edge will see, so outputs are checked
  // against the model here and then the model advances by that edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!resetn) begin
        checkOutput("rst_m_tvalid", mIf.tvalid, 0);
        checkOutput("rst_s_tready", sIf.tready, 0);
        checkOutput("rst_pkt_cnt", statPktCnt, 0);
        checkOutput("rst_byte_cnt", statByteCnt, 0);
        checkOutput("rst_max_len", statMaxLen, 0);
        expQ.delete();
        mInPkt  = 1'b0;
        mCurLen = 0;
        mPkt    = '0;
        mByte   = '0;
        mMax    = '0;
        postRst = 1'b1;
      end else begin
        checkOutput("stat_pkt_cnt", statPktCnt, mPkt);
        checkOutput("stat_byte_cnt", statByteCnt, mByte);
        checkOutput("stat_max_len", statMaxLen, mMax);
        checkOutput("m_tvalid", mIf.tvalid, (expQ.size() > 0));
        checkOutput("s_tready", sIf.tready, (!postRst && expQ.size() < 2));
        postRst = 1'b0;
        if (mIf.tvalid && mIf.tready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", mIf.tvalid, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("m_tdata", mIf.tdata, e.data);
            checkOutput("m_tkeep", mIf.tkeep, e.keep);
            checkOutput("m_tuser", mIf.tuser, e.user);
            checkOutput("m_tlast", mIf.tlast, e.last);
          end
        end
        if (sIf.tvalid && sIf.tready) modelAccept();
        if (statsClear) begin
          mPkt  = '0;
          mByte = '0;
          mMax  = '0;
        end
      end
    end
  end

  // One idle cycle on the input side; returns on the falling edge.
  task automatic idle();
    @(negedge clk);
    sIf.tvalid = 1'b0;
    tbClear    = 1'b0;
  endtask

  // Present one beat and hold it until the DUT takes it (bounded wait).
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic [UW-1:0] u, input logic l);
    int n = 0;
    @(negedge clk);
    sIf.tdata  = d;
    sIf.tkeep  = k;
    sIf.tuser  = u;
    sIf.tlast  = l;
    sIf.tvalid = 1'b1;
    tbClear    = clearNext;
    clearNext  = 1'b0;
    #1;
    while (!sIf.tready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("accept_wait", sIf.tready, 1);
  endtask

  // Random-payload packet with the given stamp in beat 0 and a partial last beat.
  task automatic sendPkt(input int nBeats, input int lastBytes, input logic [63:0] stamp);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    for (int b = 0; b < nBeats; b++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) u[w*32 +: 32] = $urandom;
      if (b == 0) d[239:176] = stamp;
      k = '1;
      if (b == nBeats - 1) begin
        k = '0;
        for (int i = 0; i < lastBytes; i++) k[i] = 1'b1;
      end
      if (randGaps && ($urandom_range(0, 3) == 0)) idle();
      applyStimulus(d, k, u, (b == nBeats - 1));
    end
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
    sIf.tdata  = '0;
    sIf.tkeep  = '0;
    sIf.tuser  = '0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    $display("[TB] single 64B beat with stamp");
    sendPkt(1, 64, 64'h1122334455667788);
    idle();
    #4;
    checkOutput("t1_m_tvalid", mIf.tvalid, 1);
    checkOutput("t1_tuser_stamp", mIf.tuser[127:64], 64'h1122334455667788);
    checkOutput("t1_pkt_cnt", statPktCnt, 1);
    checkOutput("t1_byte_cnt", statByteCnt, 64);
    checkOutput("t1_max_len", statMaxLen, 64);

    $display("[TB] three-beat 150B packet");
    sendPkt(3, 22, 64'h00000000000000A5);
    idle();
    #4;
    checkOutput("t2_pkt_cnt", statPktCnt, 2);
    checkOutput("t2_byte_cnt", statByteCnt, 214);
    checkOutput("t2_max_len", statMaxLen, 150);

    $display("[TB] downstream stall fills the skid");
    repeat (3) idle();
    tbReady = 1'b0;
    fork
      sendPkt(5, 64, 64'h0F0E0D0C0B0A0908);
      begin
        repeat (3) @(negedge clk);
        #2;
        checkOutput("t3_s_tready_low", sIf.tready, 0);
        @(negedge clk);
        tbReady = 1'b1;
      end
    join
    repeat (4) idle();

    $display("[TB] clear coinciding with a packet end");
    clearNext = 1'b1;
    sendPkt(1, 64, 64'h5555AAAA5555AAAA);
    idle();
    #4;
    checkOutput("t4_pkt_after_clear", statPktCnt, 0);
    checkOutput("t4_byte_after_clear", statByteCnt, 0);
    checkOutput("t4_max_after_clear", statMaxLen, 0);
    sendPkt(1, 64, 64'h0123456789ABCDEF);
    idle();
    #4;
    checkOutput("t4_pkt_next", statPktCnt, 1);
    checkOutput("t4_byte_next", statByteCnt, 64);

    $display("[TB] randomized traffic");
    idle();
    randMode = 1'b1;
    randGaps = 1'b1;
    for (int p = 0; p < 120; p++)
      sendPkt($urandom_range(1, 5), $urandom_range(1, 64), {$urandom, $urandom});
    idle();
    randMode = 1'b0;
    randGaps = 1'b0;
    tbReady  = 1'b1;
    repeat (8) idle();

    $display("[TB] packet counter wrap");
    @(negedge clk);
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    mPkt = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt;
    idle();
    sendPkt(1, 64, 64'h7777777777777777);
    idle();
    #4;
    checkOutput("t5_pkt_wrapped", statPktCnt, 0);

    $display("[TB] reset in the middle of a packet");
    repeat (2) idle();
    sendPkt(1, 64, 64'h1111111111111111);
    applyStimulus({DW{1'b1}}, {KW{1'b1}}, {UW{1'b0}}, 1'b0);
    applyStimulus({DW{1'b0}}, {KW{1'b1}}, {UW{1'b1}}, 1'b0);
    @(negedge clk);
    resetn     = 1'b0;
    sIf.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sendPkt(1, 64, 64'hDEADBEEFCAFEF00D);
    idle();
    #4;
    checkOutput("t6_tuser_stamp", mIf.tuser[127:64], 64'hDEADBEEFCAFEF00D);
    checkOutput("t6_pkt_cnt", statPktCnt, 1);
    checkOutput("t6_byte_cnt", statByteCnt, 64);
    checkOutput("t6_max_len", statMaxLen, 64);

    repeat (5) idle();
    #4;
    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
